larpix_cfg_sequencer: RTL and testbench
=======================================

Name: larpix_cfg_sequencer

Overview:
Shares the single FPGA-side UART TX path (64-bit LArPix packets) between NUM_REQ configuration requesters using round-robin arbitration. Builds config write/read packets, sequences the load/busy handshake with the UART TX, and, for reads, waits for the matching config-read reply from the UART RX. Returns a per-transaction response (data and status) to the granted requester. Sits between test/control masters and the uart_tx_fpga / uart_rx_fpga pair.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MAGIC, 32'h89_50_4E_47, magic number placed in packet bits [57:26]
TIMEOUT_CYCLES, 2048, clk cycles to wait for a read reply before timeout
IDW, $clog2(NUM_REQ), requester index width (local, derived)

Ports:
clk  in  1  system clock (same clock as UART txclk/clk_rx)
reset  in  1  asynchronous active-high reset
req_valid  in  NUM_REQ  per-requester transaction request; held until req_ready
req_ready  out  NUM_REQ  one-cycle accept pulse to the granted requester
req_op  in  NUM_REQ  1 = read, 0 = write
req_chip_id  in  8*NUM_REQ  target chip ID (8'hFF = broadcast)
req_addr  in  8*NUM_REQ  register map address
req_data  in  8*NUM_REQ  write data (ignored for reads)
tx_data  out  64  packet to UART TX
ld_tx_data  out  1  one-cycle load strobe to UART TX
tx_busy  in  1  UART TX busy
rx_valid  in  1  one-cycle strobe: rx_data holds a newly unloaded packet
rx_data  in  63  received packet (parity bit stripped)
rx_parity_error  in  1  parity flag qualified by rx_valid
rsp_valid  out  1  one-cycle response strobe
rsp_id  out  IDW  requester index of the response
rsp_data  out  8  read data (0 for writes)
rsp_status  out  2  0 OK, 1 TIMEOUT, 2 PARITY, 3 reserved
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0; FSM = IDLE; round-robin pointer = 0 (requester 0 has highest priority first).
- Packet: [1:0]=2'b10 write / 2'b11 read; [9:2]=chip_id; [17:10]=addr; [25:18]=data (0 on read); [57:26]=MAGIC; [62:58]=0; [63]=odd parity, i.e. ~^[62:0].
- FSM: IDLE -> GRANT -> LOAD -> WAIT_BUSY -> WAIT_DONE -> (write: RESP | read: WAIT_RSP -> RESP) -> IDLE.
- IDLE: if any req_valid, choose the first asserted index starting at pointer+1 (wrapping modulo NUM_REQ) and go to GRANT; after the first grant following reset, the pointer advances to the granted index.
- GRANT: pulse req_ready[idx]; capture op/chip/addr/data; register tx_data. The requester may drop req_valid from the next cycle.
- LOAD: ld_tx_data=1 for exactly 1 cycle while tx_data is stable; tx_data holds until the next GRANT.
- WAIT_BUSY: wait for tx_busy=1. If tx_busy is already high at LOAD, proceed the next cycle.
- WAIT_DONE: wait for tx_busy=0.
- WAIT_RSP: 16-bit counter clears on entry and increments each cycle. Match condition: rx_valid && rx_data[1:0]==2'b11 && rx_data[17:10]==addr && (chip==8'hFF || rx_data[9:2]==chip). Non-matching packets are ignored.
  - Match with rx_parity_error=1 -> status PARITY.
  - Match otherwise -> status OK, rsp_data = rx_data[25:18].
  - Counter reaching TIMEOUT_CYCLES-1 with no match -> status TIMEOUT.
  - Match and timeout in the same cycle: match wins.
- RESP: rsp_valid=1 for 1 cycle with rsp_id, rsp_data, rsp_status; then IDLE. Writes always report OK with rsp_data=0.
- Minimum write latency: req_valid to rsp_valid is 4 cycles plus the UART frame time.
- Reset asserted mid-transaction aborts it; no response is generated and no ld_tx_data is issued.

Optional Feature:
LARPIX_CFG_RETRY_EN: when defined, a TIMEOUT or PARITY result on a read re-enters LOAD with the same packet, up to 2 retries (3 attempts total). Status is reported only after the final attempt; rsp_status reflects the last attempt. When undefined, there are no retries and the first failure is reported.

Test Plan:
- Single write: req0 write chip 8'h10, addr 8'h01, data 8'hA5 -> one ld_tx_data; tx_data[25:0] = {8'hA5, 8'h01, 8'h10, 2'b10}; [57:26]=MAGIC; parity correct; rsp_valid id=0, status 0, data 0.
- Read OK: req2 read chip 8'h1F, addr 8'h07; inject a reply with declare 3, chip 8'h1F, addr 8'h07, data 8'h3C -> rsp id=2, data 8'h3C, status 0.
- Filter: during a read, inject a data packet (declare 1) and a read reply with addr 8'h08 before the correct reply -> only the correct reply completes; exactly one rsp.
- Timeout: read with no reply -> status 1 exactly TIMEOUT_CYCLES cycles after WAIT_RSP entry. With LARPIX_CFG_RETRY_EN: 3 ld_tx_data pulses, then status 1.
- Round-robin: req0..req3 held valid, 8 writes -> grant order 0,1,2,3,0,1,2,3; no requester gets two grants while another is pending.
- Reset mid-read: assert reset during WAIT_RSP -> all outputs 0 immediately, no rsp_valid; the next request proceeds normally.

Source files
------------

// File: rtl/larpix_cfg_sequencer.sv
// Round-robin arbiter and packet sequencer sharing one LArPix UART TX/RX pair
// between NUM_REQ config requesters. Define LARPIX_CFG_RETRY_EN for read retries.
module larpix_cfg_sequencer #(
  parameter int unsigned  NUM_REQ        = 4,
  parameter logic [31:0]  MAGIC          = 32'h89_50_4E_47,
  parameter int unsigned  TIMEOUT_CYCLES = 2048,
  localparam int unsigned IDW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ-1:0]   req_op,
  input  logic [8*NUM_REQ-1:0] req_chip_id,
  input  logic [8*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [63:0]          tx_data,
  output logic                 ld_tx_data,
  input  logic                 tx_busy,
  input  logic                 rx_valid,
  input  logic [62:0]          rx_data,
  input  logic                 rx_parity_error,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [7:0]           rsp_data,
  output logic [1:0]           rsp_status,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_LOAD, S_WAIT_BUSY, S_WAIT_DONE, S_WAIT_RSP, S_RESP
  } state_t;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_TIMEOUT = 2'd1;
  localparam logic [1:0] ST_PARITY  = 2'd2;

  state_t         state_q, state_d;
  logic [IDW-1:0] idx_q, idx_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic           first_q, first_d;
  logic           op_q, op_d;
  logic [7:0]     chip_q, chip_d;
  logic [7:0]     addr_q, addr_d;
  logic [63:0]    tx_data_q, tx_data_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [1:0]     status_q, status_d;
  logic [7:0]     rdata_q, rdata_d;
`ifdef LARPIX_CFG_RETRY_EN
  logic [1:0]     retry_q, retry_d;
`endif

  logic           arb_found;
  logic [IDW-1:0] arb_pick;
  logic           rx_match;
  logic           rx_unused;

  assign rx_unused = ^rx_data[62:26];

  function automatic logic [63:0] build_pkt(input logic rd, input logic [7:0] chip,
                                            input logic [7:0] addr, input logic [7:0] data);
    logic [62:0] body;
    body = {5'b0, MAGIC, (rd ? 8'h00 : data), addr, chip, 1'b1, rd};
    return {~^body, body};
  endfunction

  // Before the first grant after reset, the search starts at requester 0.
  always_comb begin
    int unsigned start;
    int unsigned cand;
    arb_found = 1'b0;
    arb_pick  = '0;
    start     = first_q ? 0 : 32'(ptr_q) + 1;
    if (start >= NUM_REQ) start = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = start + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!arb_found && req_valid[IDW'(cand)]) begin
        arb_found = 1'b1;
        arb_pick  = IDW'(cand);
      end
    end
  end

  assign rx_match = rx_valid && (rx_data[1:0] == 2'b11) && (rx_data[17:10] == addr_q) &&
                    ((chip_q == 8'hFF) || (rx_data[9:2] == chip_q));

  always_comb begin
    logic       fail;
    logic [1:0] fail_status;
    state_d     = state_q;
    idx_d       = idx_q;
    ptr_d       = ptr_q;
    first_d     = first_q;
    op_d        = op_q;
    chip_d      = chip_q;
    addr_d      = addr_q;
    tx_data_d   = tx_data_q;
    cnt_d       = cnt_q;
    status_d    = status_q;
    rdata_d     = rdata_q;
`ifdef LARPIX_CFG_RETRY_EN
    retry_d     = retry_q;
`endif
    fail        = 1'b0;
    fail_status = ST_OK;

    case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          idx_d   = arb_pick;
          ptr_d   = arb_pick;
          first_d = 1'b0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        op_d      = req_op[idx_q];
        chip_d    = req_chip_id[idx_q*8 +: 8];
        addr_d    = req_addr[idx_q*8 +: 8];
        tx_data_d = build_pkt(req_op[idx_q], req_chip_id[idx_q*8 +: 8],
                              req_addr[idx_q*8 +: 8], req_data[idx_q*8 +: 8]);
        status_d  = ST_OK;
        rdata_d   = 8'h00;
`ifdef LARPIX_CFG_RETRY_EN
        retry_d   = 2'd0;
`endif
        state_d   = S_LOAD;
      end
      S_LOAD: state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (tx_busy) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          if (op_q) begin
            cnt_d   = '0;
            state_d = S_WAIT_RSP;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT_RSP: begin
        cnt_d = cnt_q + 16'd1;
        if (rx_match) begin
          if (rx_parity_error) begin
            fail        = 1'b1;
            fail_status = ST_PARITY;
          end else begin
            status_d = ST_OK;
            rdata_d  = rx_data[25:18];
            state_d  = S_RESP;
          end
        end else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          fail        = 1'b1;
          fail_status = ST_TIMEOUT;
        end
        if (fail) begin
          status_d = fail_status;
`ifdef LARPIX_CFG_RETRY_EN
          if (retry_q != 2'd2) begin
            retry_d = retry_q + 2'd1;
            state_d = S_LOAD;
          end else begin
            state_d = S_RESP;
          end
`else
          state_d = S_RESP;
`endif
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      ptr_q     <= '0;
      first_q   <= 1'b1;
      op_q      <= 1'b0;
      chip_q    <= '0;
      addr_q    <= '0;
      tx_data_q <= '0;
      cnt_q     <= '0;
      status_q  <= '0;
      rdata_q   <= '0;
`ifdef LARPIX_CFG_RETRY_EN
      retry_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      first_q   <= first_d;
      op_q      <= op_d;
      chip_q    <= chip_d;
      addr_q    <= addr_d;
      tx_data_q <= tx_data_d;
      cnt_q     <= cnt_d;
      status_q  <= status_d;
      rdata_q   <= rdata_d;
`ifdef LARPIX_CFG_RETRY_EN
      retry_q   <= retry_d;
`endif
    end
  end

  assign req_ready  = (state_q == S_GRANT) ? (NUM_REQ'(1) << idx_q) : '0;
  assign tx_data    = tx_data_q;
  assign ld_tx_data = (state_q == S_LOAD);
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_id     = (state_q == S_RESP) ? idx_q : '0;
  assign rsp_data   = (state_q == S_RESP) ? rdata_q : '0;
  assign rsp_status = (state_q == S_RESP) ? status_q : '0;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_larpix_cfg_sequencer.sv
// Randomized bench for larpix_cfg_sequencer: UART TX/RX stand-ins plus a
// transaction-level reference for arbitration order, packet format and responses.
module tb_larpix_cfg_sequencer;
  localparam int unsigned N     = 4;
  localparam int unsigned T     = 64;
  localparam logic [31:0] MAGIC = 32'h89_50_4E_47;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid, req_ready, req_op;
  logic [8*N-1:0] req_chip_id, req_addr, req_data;
  logic [63:0]   tx_data;
  logic          ld_tx_data, tx_busy, rx_valid, rx_parity_error;
  logic [62:0]   rx_data;
  logic          rsp_valid, busy;
  logic [1:0]    rsp_id, rsp_status;
  logic [7:0]    rsp_data;

  larpix_cfg_sequencer #(.NUM_REQ(N), .MAGIC(MAGIC), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_chip_id(req_chip_id), .req_addr(req_addr), .req_data(req_data),
    .tx_data(tx_data), .ld_tx_data(ld_tx_data), .tx_busy(tx_busy),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_parity_error(rx_parity_error),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_status(rsp_status), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0, n_err = 0, n_txn = 0;
  int unsigned cyc = 0, ld_cnt = 0, fall_cnt = 0, rsp_cnt = 0, last_fall_cyc = 0;
  logic [63:0] last_pkt = '0;

  logic       t_op   [N];
  logic [7:0] t_chip [N], t_addr [N], t_data [N];
  int         t_mode [N];   // read reply: 0 good, 1 parity error, 2 none

  logic       cur_read = 1'b0;
  int         cur_mode = 0;
  logic [7:0] cur_chip = '0, cur_addr = '0, cur_rdata = '0;

  bit m_first = 1'b1;
  int m_ptr   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rsp_valid) rsp_cnt++;

  function automatic logic [63:0] exp_pkt(input logic rd, input logic [7:0] chip,
                                          input logic [7:0] addr, input logic [7:0] data);
    logic [63:0] p;
    p          = '0;
    p[1:0]     = rd ? 2'b11 : 2'b10;
    p[9:2]     = chip;
    p[17:10]   = addr;
    p[25:18]   = rd ? 8'h00 : data;
    p[57:26]   = MAGIC;
    p[63]      = ~^p[62:0];
    return p;
  endfunction

  function automatic logic [62:0] rx_pkt(input logic [1:0] decl, input logic [7:0] chip,
                                         input logic [7:0] addr, input logic [7:0] data);
    logic [62:0] r;
    r        = '0;
    r[1:0]   = decl;
    r[9:2]   = chip;
    r[17:10] = addr;
    r[25:18] = data;
    r[57:26] = MAGIC;
    return r;
  endfunction

  // Round robin: first pick after reset scans from 0, later picks start after the last grant.
  function automatic int model_pick(input logic [N-1:0] mask);
    int s;
    s = m_first ? 0 : (m_ptr + 1) % N;
    for (int k = 0; k < N; k++)
      if (mask[(s + k) % N]) return (s + k) % N;
    return -1;
  endfunction

  // UART TX stand-in: random start delay and frame length after each load strobe.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (ld_tx_data) begin
        ld_cnt++;
        last_pkt = tx_data;
        @(posedge clk);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat ($urandom_range(2, 8)) @(posedge clk);
        #1 tx_busy = 1'b0;
        last_fall_cyc = cyc;
        fall_cnt++;
      end
    end
  end

  // UART RX stand-in: after each frame of a read, send decoys then the reply.
  initial begin
    int unsigned seen;
    int unsigned nj;
    seen = 0;
    rx_valid = 1'b0; rx_data = '0; rx_parity_error = 1'b0;
    forever begin
      @(posedge clk);
      if (fall_cnt != seen) begin
        seen = fall_cnt;
        if (cur_read && cur_mode != 2) begin
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
          nj = $urandom_range(1, 3);
          for (int j = 0; j < int'(nj); j++) begin
            case (j % 3)
              0: rx_data = rx_pkt(2'b01, cur_chip, cur_addr, 8'($urandom));
              1: rx_data = rx_pkt(2'b11, cur_chip, cur_addr + 8'd1, 8'($urandom));
              default: rx_data = (cur_chip == 8'hFF) ?
                                 rx_pkt(2'b10, cur_chip, cur_addr, 8'($urandom)) :
                                 rx_pkt(2'b11, cur_chip ^ 8'h01, cur_addr, 8'($urandom));
            endcase
            rx_valid = 1'b1;
            rx_parity_error = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
          end
          rx_valid = 1'b1;
          rx_data  = rx_pkt(2'b11, (cur_chip == 8'hFF) ? 8'($urandom) : cur_chip,
                            cur_addr, cur_rdata);
          rx_parity_error = (cur_mode == 1);
          @(posedge clk); #1;
          rx_valid = 1'b0; rx_parity_error = 1'b0;
        end
      end
    end
  end

  task automatic set_req(input int i, input logic op, input logic [7:0] chip,
                         input logic [7:0] addr, input logic [7:0] data, input int mode);
    t_op[i] = op; t_chip[i] = chip; t_addr[i] = addr; t_data[i] = data; t_mode[i] = mode;
    req_op[i] = op;
    req_chip_id[i*8 +: 8] = chip;
    req_addr[i*8 +: 8]    = addr;
    req_data[i*8 +: 8]    = data;
  endtask

  task automatic rand_req(input int i);
    logic op;
    int   r;
    op = 1'($urandom_range(0, 1));
    r  = $urandom_range(0, 9);
    set_req(i, op, ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom),
            8'($urandom), 8'($urandom), (r < 6) ? 0 : (r < 8) ? 1 : 2);
  endtask

  task automatic wait_grant(output int g, output bit ok);
    int exp_g;
    exp_g = model_pick(req_valid);
    ok = 1'b0;
    for (int k = 0; k < 30 && !ok; k++) begin
      @(negedge clk);
      if (req_ready != '0) ok = 1'b1;
    end
    if (!ok) begin
      check("grant_seen", 0, 1);
      g = 0;
      return;
    end
    check("grant_onehot", req_ready, 64'(1) << exp_g);
    g = exp_g;
    m_ptr = exp_g; m_first = 1'b0;
    cur_read = t_op[g]; cur_mode = t_mode[g];
    cur_chip = t_chip[g]; cur_addr = t_addr[g]; cur_rdata = t_data[g];
  endtask

  task automatic run_one(output int g);
    bit          ok;
    int unsigned ld0;
    int          attempts;
    logic [1:0]  exp_st;
    wait_grant(g, ok);
    if (!ok) return;
    ld0 = ld_cnt;
    @(posedge clk); #1 req_valid[g] = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 4 * (T + 60) && !ok; k++) begin
      @(negedge clk);
      if (rsp_valid) ok = 1'b1;
    end
    if (!ok) begin
      check("rsp_seen", 0, 1);
      cur_read = 1'b0;
      return;
    end
    if (!t_op[g] || t_mode[g] == 0) begin
      exp_st = 2'd0; attempts = 1;
    end else begin
      exp_st = (t_mode[g] == 1) ? 2'd2 : 2'd1;
`ifdef LARPIX_CFG_RETRY_EN
      attempts = 3;
`else
      attempts = 1;
`endif
    end
    check("rsp_id", rsp_id, g);
    check("rsp_status", rsp_status, exp_st);
    if (exp_st == 2'd0) check("rsp_data", rsp_data, t_op[g] ? t_data[g] : 8'h00);
    if (exp_st == 2'd1) check("timeout_latency", cyc, last_fall_cyc + 1 + T);
    check("ld_pulses", ld_cnt - ld0, attempts);
    check("tx_packet", last_pkt, exp_pkt(t_op[g], t_chip[g], t_addr[g], t_data[g]));
    n_txn++;
    cur_read = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_ld"}, ld_tx_data, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_id"}, rsp_id, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_rsp_status"}, rsp_status, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int          g;
    bit          ok;
    int unsigned f0, ld0, rsp0;
    rst = 1'b1;
    req_valid = '0; req_op = '0; req_chip_id = '0; req_addr = '0; req_data = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    // Directed write from requester 0
    @(posedge clk); #1;
    set_req(0, 1'b0, 8'h10, 8'h01, 8'hA5, 0);
    req_valid[0] = 1'b1;
    run_one(g);
    check("wr_low26", last_pkt[25:0], {8'hA5, 8'h01, 8'h10, 2'b10});

    // Directed read from requester 2, decoys precede the reply
    @(posedge clk); #1;
    set_req(2, 1'b1, 8'h1F, 8'h07, 8'h3C, 0);
    req_valid[2] = 1'b1;
    run_one(g);

    // Read with no reply
    @(posedge clk); #1;
    set_req(1, 1'b1, 8'h33, 8'h09, 8'h00, 2);
    req_valid[1] = 1'b1;
    run_one(g);

    // Round robin with all requesters pending; fresh reset so scanning starts at 0
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    m_first = 1'b1; m_ptr = 0;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      set_req(i, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 0);
      req_valid[i] = 1'b1;
    end
    for (int k = 0; k < 2 * N; k++) begin
      run_one(g);
      check("rr_order", g, k % N);
      @(posedge clk); #1;
      if (k < N) begin
        set_req(g, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 0);
        req_valid[g] = 1'b1;
      end
    end

    // Random traffic with random request masks
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          rand_req(i);
          req_valid[i] = 1'b1;
        end
      if (req_valid == '0) begin
        g = $urandom_range(0, N - 1);
        rand_req(g);
        req_valid[g] = 1'b1;
      end
      run_one(g);
      @(posedge clk); #1;
    end
    req_valid = '0;
    repeat (2) @(posedge clk);

    // Reset while waiting for a read reply
    #1;
    set_req(1, 1'b1, 8'h22, 8'h05, 8'h00, 2);
    req_valid[1] = 1'b1;
    wait_grant(g, ok);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    f0 = fall_cnt;
    for (int k = 0; k < 100 && fall_cnt == f0; k++) @(posedge clk);
    check("rst_frame_done", fall_cnt != f0, 1);
    repeat (5) @(posedge clk);
    #1 check("rst_busy_before", busy, 1);
    ld0 = ld_cnt; rsp0 = rsp_cnt;
    rst = 1'b1;
    #1 check_idle_outputs("midrst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cur_read = 1'b0;
    m_first = 1'b1; m_ptr = 0;
    check("midrst_no_ld", ld_cnt, ld0);
    check("midrst_no_rsp", rsp_cnt, rsp0);
    @(posedge clk); #1;
    set_req(0, 1'b0, 8'h44, 8'h02, 8'h5A, 0);
    set_req(2, 1'b1, 8'hFF, 8'h0B, 8'hC3, 0);
    req_valid[0] = 1'b1; req_valid[2] = 1'b1;
    run_one(g);
    check("post_rst_first", g, 0);
    run_one(g);
    check("post_rst_second", g, 2);

    repeat (4) @(posedge clk);
    check("rsp_total", rsp_cnt, n_txn);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #5000000;
    check("global_timeout", 0, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $fatal(1, "simulation time limit");
  end
endmodule
